// File: rtl/dr_beam_serializer.sv
// Serializes wide multi-beam DR beats into 64-bit words (header + two beams per word)
// through a small tagged FIFO and a registered IDLE/HDR/BODY output FSM.
module dr_beam_serializer #(
  parameter int BEAM  = 16,
  parameter int IW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_dr_vld,
  input  logic                   i_dr_sop,
  input  logic                   i_dr_eop,
  input  logic [BEAM*IW-1:0]     i_dr_data,
  input  logic [3:0]             i_pkg_type,
  input  logic                   i_cell_idx,
  input  logic [6:0]             i_slot_idx,
  input  logic [3:0]             i_symb_idx,
  input  logic [3:0]             i_rbg_idx,
  output logic [63:0]            o_tx_data,
  output logic                   o_tx_vld,
  output logic                   o_tx_sop,
  output logic                   o_tx_eop,
  input  logic                   i_tx_rdy,
  output logic                   o_ovf,
  output logic                   o_err_sop,
  output logic [$clog2(DEPTH):0] o_fifo_cnt
);
  // state | meaning
  // IDLE  | no word presented, waiting for a sop entry at the FIFO head
  // HDR   | header word of the head entry is presented
  // BODY  | body word k of the head entry is presented (or waiting for data when o_tx_vld=0)
  typedef enum logic [1:0] {IDLE, HDR, BODY} state_t;

  localparam int AW = $clog2(DEPTH);
  localparam int NW = BEAM / 2;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int DW = BEAM * IW;
  localparam logic [KW-1:0] LAST = KW'(NW - 1);
  localparam logic [AW:0]   FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   ONE  = (AW+1)'(1);

  state_t        state, state_d;
  logic [KW-1:0] k, k_d;

  logic [DW-1:0] mem_data [DEPTH];
  logic [19:0]   mem_tag  [DEPTH];
  logic          mem_sop  [DEPTH];
  logic          mem_eop  [DEPTH];

  logic [AW-1:0] wr_ptr, rd_ptr, nx_ptr;
  logic [AW:0]   cnt_d;
  logic [19:0]   tag_q, tag_in;
  logic          push, pop, empty, err_set;
  logic [63:0]   data_d;
  logic          vld_d, sop_d, eop_d;

  logic [DW-1:0] head_data, nxt_data;
  logic [19:0]   head_tag, nxt_tag;
  logic          head_sop, head_eop, nxt_sop, nxt_eop;

  function automatic logic [63:0] hdr_word(input logic [19:0] tag);
    return {tag, 44'd0};
  endfunction

  function automatic logic [63:0] body_word(input logic [DW-1:0] d, input logic [KW-1:0] idx);
    logic [31:0] hi, lo;
    lo = 32'(d[2*int'(idx)*IW +: IW]);
    hi = 32'(d[(2*int'(idx)+1)*IW +: IW]);
    return {hi, lo};
  endfunction

  // Tags are latched at sop so every beat of a packet carries them
  assign tag_in = (i_dr_vld && i_dr_sop) ?
                  {i_pkg_type, i_cell_idx, i_slot_idx, i_symb_idx, i_rbg_idx} : tag_q;

  assign nx_ptr    = rd_ptr + AW'(1);
  assign head_data = mem_data[rd_ptr];
  assign head_tag  = mem_tag[rd_ptr];
  assign head_sop  = mem_sop[rd_ptr];
  assign head_eop  = mem_eop[rd_ptr];
  assign nxt_data  = mem_data[nx_ptr];
  assign nxt_tag   = mem_tag[nx_ptr];
  assign nxt_sop   = mem_sop[nx_ptr];
  assign nxt_eop   = mem_eop[nx_ptr];

  assign empty = (o_fifo_cnt == '0);
  assign push  = i_dr_vld && ((o_fifo_cnt != FULL) || pop);

  always_comb begin
    state_d = state;
    k_d     = k;
    pop     = 1'b0;
    err_set = 1'b0;
    data_d  = o_tx_data;
    vld_d   = o_tx_vld;
    sop_d   = o_tx_sop;
    eop_d   = o_tx_eop;
    case (state)
      IDLE: begin
        if (!empty) begin
          if (head_sop) begin
            state_d = HDR;
            data_d  = hdr_word(head_tag);
            vld_d   = 1'b1;
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end else begin
            pop     = 1'b1;
            err_set = 1'b1;
          end
        end
      end
      HDR: begin
        if (o_tx_vld && i_tx_rdy) begin
          state_d = BODY;
          k_d     = '0;
          data_d  = body_word(head_data, '0);
          sop_d   = 1'b0;
          eop_d   = (LAST == '0) && head_eop;
        end
      end
      BODY: begin
        if (o_tx_vld) begin
          if (i_tx_rdy) begin
            if (k != LAST) begin
              k_d    = k + KW'(1);
              data_d = body_word(head_data, k_d);
              sop_d  = 1'b0;
              eop_d  = (k_d == LAST) && head_eop;
            end else begin
              pop = 1'b1;
              k_d = '0;
              if (head_eop) begin
                state_d = IDLE;
                data_d  = '0;
                vld_d   = 1'b0;
                sop_d   = 1'b0;
                eop_d   = 1'b0;
              end else if (o_fifo_cnt > ONE) begin
                // Look past the entry being popped so beats stream without a gap
                if (nxt_sop) begin
                  state_d = HDR;
                  err_set = 1'b1;
                  data_d  = hdr_word(nxt_tag);
                  sop_d   = 1'b1;
                  eop_d   = 1'b0;
                end else begin
                  data_d = body_word(nxt_data, '0);
                  sop_d  = 1'b0;
                  eop_d  = (LAST == '0) && nxt_eop;
                end
              end else begin
                vld_d = 1'b0;
                sop_d = 1'b0;
                eop_d = 1'b0;
              end
            end
          end
        end else if (!empty) begin
          vld_d = 1'b1;
          k_d   = '0;
          if (head_sop) begin
            state_d = HDR;
            err_set = 1'b1;
            data_d  = hdr_word(head_tag);
            sop_d   = 1'b1;
            eop_d   = 1'b0;
          end else begin
            data_d = body_word(head_data, '0);
            sop_d  = 1'b0;
            eop_d  = (LAST == '0) && head_eop;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case ({push, pop})
      2'b10:   cnt_d = o_fifo_cnt + ONE;
      2'b01:   cnt_d = o_fifo_cnt - ONE;
      default: cnt_d = o_fifo_cnt;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state      <= IDLE;
      k          <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_q      <= '0;
      o_fifo_cnt <= '0;
      o_tx_data  <= '0;
      o_tx_vld   <= 1'b0;
      o_tx_sop   <= 1'b0;
      o_tx_eop   <= 1'b0;
      o_ovf      <= 1'b0;
      o_err_sop  <= 1'b0;
    end else begin
      state      <= state_d;
      k          <= k_d;
      tag_q      <= tag_in;
      o_fifo_cnt <= cnt_d;
      o_tx_data  <= data_d;
      o_tx_vld   <= vld_d;
      o_tx_sop   <= sop_d;
      o_tx_eop   <= eop_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= nx_ptr;
      if (i_dr_vld && !push) o_ovf <= 1'b1;
      if (err_set) o_err_sop <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_data[wr_ptr] <= i_dr_data;
      mem_tag[wr_ptr]  <= tag_in;
      mem_sop[wr_ptr]  <= i_dr_sop;
      mem_eop[wr_ptr]  <= i_dr_eop;
    end
  end

endmodule

// File: tb/tb_dr_beam_serializer.sv
// Scoreboard bench for dr_beam_serializer: directed packets push expected words,
// a monitor pops and compares each accepted word and checks stall stability.
module tb_dr_beam_serializer;
  localparam int BEAM  = 16;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam logic [19:0] TAG1 = {4'h3, 1'b0, 7'd5,  4'd2, 4'd1};
  localparam logic [19:0] TAG3 = {4'hA, 1'b1, 7'd99, 4'd7, 4'd12};
  localparam logic [19:0] TAGJ = {4'h5, 1'b1, 7'd3,  4'd9, 4'd4};
  localparam logic [19:0] TAGA = {4'h1, 1'b0, 7'd64, 4'd15, 4'd0};
  localparam logic [19:0] TAGB = {4'hF, 1'b1, 7'd127, 4'd1, 4'd8};

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 dr_vld, dr_sop, dr_eop;
  logic [BEAM*IW-1:0]   dr_data;
  logic [3:0]           pkg_type;
  logic                 cell_idx;
  logic [6:0]           slot_idx;
  logic [3:0]           symb_idx, rbg_idx;
  logic [63:0]          tx_data;
  logic                 tx_vld, tx_sop, tx_eop, tx_rdy;
  logic                 ovf, err_sop;
  logic [$clog2(DEPTH):0] fifo_cnt;

  int checks = 0;
  int errors = 0;
  int n_acc  = 0;
  logic [65:0] q[$];

  dr_beam_serializer #(.BEAM(BEAM), .IW(IW), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_reset(rst_n),
    .i_dr_vld(dr_vld), .i_dr_sop(dr_sop), .i_dr_eop(dr_eop), .i_dr_data(dr_data),
    .i_pkg_type(pkg_type), .i_cell_idx(cell_idx), .i_slot_idx(slot_idx),
    .i_symb_idx(symb_idx), .i_rbg_idx(rbg_idx),
    .o_tx_data(tx_data), .o_tx_vld(tx_vld), .o_tx_sop(tx_sop), .o_tx_eop(tx_eop),
    .i_tx_rdy(tx_rdy), .o_ovf(ovf), .o_err_sop(err_sop), .o_fifo_cnt(fifo_cnt)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [BEAM*IW-1:0] mk_data(input logic [31:0] base);
    logic [BEAM*IW-1:0] d;
    d = '0;
    for (int b = 0; b < BEAM; b++) d[b*IW +: IW] = base + 32'(b);
    return d;
  endfunction

  task automatic exp_hdr(input logic [19:0] tag);
    q.push_back({2'b10, tag, 44'd0});
  endtask

  task automatic exp_beat(input logic [31:0] base, input bit eop);
    for (int k = 0; k < BEAM/2; k++)
      q.push_back({1'b0, 1'(eop && (k == BEAM/2-1)), base + 32'(2*k+1), base + 32'(2*k)});
  endtask

  task automatic drive_beat(input bit sop, input bit eop, input logic [31:0] base,
                            input logic [19:0] tag);
    dr_vld  = 1'b1;
    dr_sop  = sop;
    dr_eop  = eop;
    dr_data = mk_data(base);
    {pkg_type, cell_idx, slot_idx, symb_idx, rbg_idx} = tag;
    @(posedge clk); #1;
    dr_vld = 1'b0;
    dr_sop = 1'b0;
    dr_eop = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic drain(input bit bp, input int budget);
    int ph = 0;
    int n  = 0;
    while (q.size() != 0 && n < budget) begin
      @(posedge clk); #1;
      n++;
      if (bp) begin
        tx_rdy = (ph % 3 == 0);
        ph++;
      end
    end
    tx_rdy = 1'b1;
    chk("drain_empty", 66'(q.size()), 66'd0);
  endtask

  task automatic monitor();
    logic        stall = 1'b0;
    logic [65:0] held  = '0;
    logic [65:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) stall = 1'b0;
      else begin
        if (stall && tx_vld) chk("stall_stable", {tx_sop, tx_eop, tx_data}, held);
        if (tx_vld && tx_rdy) begin
          n_acc++;
          if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_word: got %h, expected no word", {tx_sop, tx_eop, tx_data});
          end else begin
            e = q.pop_front();
            chk("word", {tx_sop, tx_eop, tx_data}, e);
          end
        end
        stall = tx_vld && !tx_rdy;
        held  = {tx_sop, tx_eop, tx_data};
      end
    end
  endtask

  task automatic stimulus();
    int run, best, tot, n0, cyc;
    rst_n = 1'b1; dr_vld = 1'b0; dr_sop = 1'b0; dr_eop = 1'b0; dr_data = '0;
    pkg_type = '0; cell_idx = 1'b0; slot_idx = '0; symb_idx = '0; rbg_idx = '0;
    tx_rdy = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_vld",  66'(tx_vld), 66'd0);
    chk("rst_data", 66'(tx_data), 66'd0);
    chk("rst_sop_eop", 66'({tx_sop, tx_eop}), 66'd0);
    chk("rst_ovf_err", 66'({ovf, err_sop}), 66'd0);
    chk("rst_cnt",  66'(fifo_cnt), 66'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;

    // one-beat packet, latency and gapless stream
    exp_hdr(TAG1);
    exp_beat(32'h0000_0100, 1'b1);
    drive_beat(1'b1, 1'b1, 32'h0000_0100, TAG1);
    chk("lat_edge_n", 66'(tx_vld), 66'd0);
    run = 0; best = 0; tot = 0;
    for (int c = 0; c < 14; c++) begin
      @(posedge clk); #1;
      if (c == 0) chk("lat_header", {tx_vld, tx_sop, tx_data}, {2'b11, 64'h3052_1000_0000_0000});
      if (tx_vld) begin
        tot++; run++;
        if (run > best) best = run;
      end else run = 0;
    end
    chk("consecutive_run", 66'(best), 66'd9);
    chk("valid_total", 66'(tot), 66'd9);
    chk("t1_drained", 66'(q.size()), 66'd0);

    // backpressure 1,0,0 pattern
    exp_hdr(TAG1);
    exp_beat(32'h0000_0100, 1'b1);
    drive_beat(1'b1, 1'b1, 32'h0000_0100, TAG1);
    drain(1'b1, 300);

    // overflow: 5 beats into a 4-deep FIFO with no ready
    tx_rdy = 1'b0;
    exp_hdr(TAG3);
    exp_beat(32'h0000_0200, 1'b0);
    exp_beat(32'h0000_0300, 1'b0);
    exp_beat(32'h0000_0400, 1'b0);
    exp_beat(32'h0000_0500, 1'b1);
    drive_beat(1'b1, 1'b0, 32'h0000_0200, TAG3);
    drive_beat(1'b0, 1'b0, 32'h0000_0300, TAGJ);
    drive_beat(1'b0, 1'b0, 32'h0000_0400, TAGJ);
    drive_beat(1'b0, 1'b1, 32'h0000_0500, TAGJ);
    chk("full_cnt", 66'(fifo_cnt), 66'd4);
    chk("full_no_ovf", 66'(ovf), 66'd0);
    drive_beat(1'b1, 1'b1, 32'h0000_0900, TAGJ);
    chk("ovf_cnt", 66'(fifo_cnt), 66'd4);
    chk("ovf_flag", 66'(ovf), 66'd1);
    tx_rdy = 1'b1;
    drain(1'b0, 300);
    chk("ovf_drained_cnt", 66'(fifo_cnt), 66'd0);

    // beat without sop while idle is discarded
    chk("err_before", 66'(err_sop), 66'd0);
    drive_beat(1'b0, 1'b1, 32'h0000_0A00, TAG1);
    repeat (3) @(posedge clk);
    #1;
    chk("err_nosop", 66'(err_sop), 66'd1);
    chk("nosop_cnt", 66'(fifo_cnt), 66'd0);
    chk("nosop_vld", 66'(tx_vld), 66'd0);

    // new sop before eop
    do_reset();
    chk("rst_clr_flags", 66'({ovf, err_sop}), 66'd0);
    exp_hdr(TAGA);
    exp_beat(32'h0000_0600, 1'b0);
    exp_hdr(TAGB);
    exp_beat(32'h0000_0700, 1'b1);
    drive_beat(1'b1, 1'b0, 32'h0000_0600, TAGA);
    drive_beat(1'b1, 1'b1, 32'h0000_0700, TAGB);
    drain(1'b0, 300);
    chk("err_trunc", 66'(err_sop), 66'd1);

    // reset after header and three body words
    do_reset();
    exp_hdr(TAG1);
    exp_beat(32'h0000_0100, 1'b1);
    n0 = n_acc;
    drive_beat(1'b1, 1'b1, 32'h0000_0100, TAG1);
    cyc = 0;
    while (n_acc < n0 + 4 && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("mid_words_seen", 66'(n_acc - n0), 66'd4);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 66'(tx_vld), 66'd0);
    chk("mid_rst_data", 66'(tx_data), 66'd0);
    chk("mid_rst_sop_eop", 66'({tx_sop, tx_eop}), 66'd0);
    chk("mid_rst_cnt", 66'(fifo_cnt), 66'd0);
    q.delete();
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    exp_hdr(TAG3);
    exp_beat(32'h0000_0800, 1'b1);
    drive_beat(1'b1, 1'b1, 32'h0000_0800, TAG3);
    drain(1'b0, 300);
    repeat (6) @(posedge clk);
    #1;
    chk("final_cnt", 66'(fifo_cnt), 66'd0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        #200000;
        checks++;
        errors++;
        $display("FAIL global_timeout: got no completion, expected stimulus to finish");
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
